// File: rtl/mem_access_unit.sv
// M-stage load/store unit: alignment check, lane steering, bus handshake FSM and load extension.
// Optional one-entry store buffer enabled by defining MEM_STORE_BUF_EN.
module mem_access_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = DATA_W / 8,
  parameter int unsigned OFF_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [7:0]        l_s_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              addr_error_lw,
  output logic              addr_error_sw,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [LANES-1:0]  data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam int unsigned Halves = LANES / 2;
  localparam int unsigned Words  = LANES / 4;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q;
  logic [1:0]        size_q;
  logic              wr_q, sgn_q;
  logic [LANES-1:0]  wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  // l_s_type bit order: 7=lw 6=lh 5=lhu 4=lb 3=lbu 2=sw 1=sh 0=sb
  logic             is_load_in, is_store_in, is_word_in, is_half_in, mis_in, new_req;
  logic [1:0]       size_in;
  logic [OFF_W-1:0] off_in;
  logic [LANES-1:0] base_strb, wstrb_in;
  logic [DATA_W-1:0] wdata_in;

  assign is_load_in  = |l_s_type[7:3];
  assign is_store_in = |l_s_type[2:0];
  assign is_word_in  = l_s_type[7] | l_s_type[2];
  assign is_half_in  = l_s_type[6] | l_s_type[5] | l_s_type[1];
  assign mis_in      = (is_word_in & (|addr[1:0])) | (is_half_in & addr[0]);
  assign size_in     = is_word_in ? 2'd2 : (is_half_in ? 2'd1 : 2'd0);
  assign off_in      = addr[OFF_W-1:0];

  assign addr_error_lw = req_valid & is_load_in & mis_in;
  assign addr_error_sw = req_valid & is_store_in & mis_in;
  assign new_req = req_valid & (is_load_in | is_store_in) & ~mis_in & ~flush;

  // Legal word accesses have off_in[1:0]==0, so a plain shift lands on lane 4*addr[OFF_W-1:2].
  always_comb begin
    base_strb = '0;
    unique case (size_in)
      2'd0:    base_strb[0]   = 1'b1;
      2'd1:    base_strb[1:0] = 2'b11;
      default: base_strb[3:0] = 4'hF;
    endcase
    wstrb_in = is_store_in ? (base_strb << off_in) : '0;
  end

  always_comb begin
    unique case (size_in)
      2'd0:    wdata_in = {LANES{wdata[7:0]}};
      2'd1:    wdata_in = {Halves{wdata[15:0]}};
      default: wdata_in = {Words{wdata}};
    endcase
  end

  logic [DATA_W-1:0] rd_shift;
  logic [31:0]       load_ext;

  assign rd_shift = data_rdata >> {addr_q[OFF_W-1:0], 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    load_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift[31:0];
    endcase
  end

  logic busy, capture, complete;

`ifdef MEM_STORE_BUF_EN
  logic wr_pend_q, set_pend;
  // A buffered store owns the next data_ok; hold new accesses until it arrives.
  assign busy = wr_pend_q & ~data_data_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
    end else if (set_pend) begin
      wr_pend_q <= 1'b1;
    end else if (data_data_ok) begin
      wr_pend_q <= 1'b0;
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    data_req = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
`ifdef MEM_STORE_BUF_EN
    set_pend = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (new_req) begin
          stall = 1'b1;
          if (!busy) begin
            capture = 1'b1;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        data_req = 1'b1;
        stall    = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            stall    = 1'b0;
            complete = ~flush;
            state_d  = StIdle;
`ifdef MEM_STORE_BUF_EN
          end else if (wr_q) begin
            stall    = 1'b0;
            set_pend = 1'b1;
            state_d  = StIdle;
`endif
          end else begin
            state_d = flush ? StDrain : StData;
          end
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StData: begin
        stall = 1'b1;
        if (data_data_ok) begin
          stall    = 1'b0;
          complete = ~flush;
          state_d  = StIdle;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      default: begin
        stall = req_valid;
        if (data_data_ok) state_d = StIdle;
      end
    endcase
    if (rst) begin
      state_d  = StIdle;
      stall    = 1'b0;
      data_req = 1'b0;
      capture  = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= addr;
        size_q  <= size_in;
        wr_q    <= is_store_in;
        sgn_q   <= l_s_type[6] | l_s_type[4];
        wstrb_q <= wstrb_in;
        wdata_q <= wdata_in;
      end
    end
  end

  assign rdata_valid = complete & ~wr_q;
  assign rdata       = rdata_valid ? load_ext : '0;
  assign data_wr     = data_req & wr_q;
  assign data_size   = size_q;
  assign data_addr   = addr_q;
  assign data_wstrb  = wstrb_q;
  assign data_wdata  = wdata_q;

endmodule
